// File: rtl/tinyalu_arbiter_if.sv
// Requester/response and tinyalu-side signal bundle for tinyalu_arbiter.
// slave: arbiter view; master: requester/ALU environment view.
interface tinyalu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic [2:0]  req0_op;
  logic        rsp0_valid;
  logic [15:0] rsp0_result;
  logic        rsp0_err;

  logic        req1_valid;
  logic        req1_ready;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;
  logic [2:0]  req1_op;
  logic        rsp1_valid;
  logic [15:0] rsp1_result;
  logic        rsp1_err;

  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic [15:0] alu_result;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_err,
    output alu_a, alu_b, alu_op, alu_start,
    input  alu_done, alu_result
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_err,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_err,
    input  alu_a, alu_b, alu_op, alu_start,
    output alu_done, alu_result
  );
endinterface

// File: rtl/tinyalu_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of one tinyalu.
// Optional BUSY watchdog: define TINYALU_ARB_TIMEOUT_EN.
module tinyalu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned TO_W           = 4
) (
  input  logic             clk,
  input  logic             reset,
  tinyalu_arbiter_if.slave bus
);

  localparam int unsigned D_W  = 8;
  localparam int unsigned OP_W = 3;
  localparam int unsigned R_W  = 16;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  if ((TO_W < 32) && ((64'd1 << TO_W) <= 64'(TIMEOUT_CYCLES))) begin : g_cfg_check
    $error("tinyalu_arbiter: TO_W too narrow for TIMEOUT_CYCLES");
  end

  state_e            state_q, state_d;
  logic              rr_q, rr_d;
  logic              g_q, g_d;
  logic [D_W-1:0]    a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              start_q, start_d;
  logic              rsp0_valid_q, rsp0_valid_d, rsp1_valid_q, rsp1_valid_d;
  logic [R_W-1:0]    rsp0_result_q, rsp0_result_d, rsp1_result_q, rsp1_result_d;
  logic              rsp0_err_q, rsp0_err_d, rsp1_err_q, rsp1_err_d;
`ifdef TINYALU_ARB_TIMEOUT_EN
  logic [TO_W-1:0]   to_q, to_d;
`endif

  // Grant: sole requester wins; on contention the rr pointer decides.
  logic            gnt_c;
  logic            ready0_c, ready1_c;
  logic [D_W-1:0]  sel_a_c, sel_b_c;
  logic [OP_W-1:0] sel_op_c;

  assign gnt_c    = (bus.req0_valid && bus.req1_valid) ? rr_q : bus.req1_valid;
  assign ready0_c = !reset && (state_q == IDLE) && bus.req0_valid && !gnt_c;
  assign ready1_c = !reset && (state_q == IDLE) && bus.req1_valid && gnt_c;
  assign sel_a_c  = gnt_c ? bus.req1_a  : bus.req0_a;
  assign sel_b_c  = gnt_c ? bus.req1_b  : bus.req0_b;
  assign sel_op_c = gnt_c ? bus.req1_op : bus.req0_op;

  logic           resp_fire;
  logic           resp_g;
  logic [R_W-1:0] resp_result;
  logic           resp_err;

  always_comb begin
    state_d       = state_q;
    rr_d          = rr_q;
    g_d           = g_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    start_d       = 1'b0;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_result_d = rsp0_result_q;
    rsp1_result_d = rsp1_result_q;
    rsp0_err_d    = rsp0_err_q;
    rsp1_err_d    = rsp1_err_q;
    resp_fire     = 1'b0;
    resp_g        = g_q;
    resp_result   = '0;
    resp_err      = 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
    to_d          = to_q;
`endif

    case (state_q)
      IDLE: begin
        if (ready0_c || ready1_c) begin
          g_d    = gnt_c;
          a_d    = sel_a_c;
          b_d    = sel_b_c;
          op_d   = sel_op_c;
          resp_g = gnt_c;
          case (sel_op_c)
            3'd0: begin
              state_d   = RESP;
              resp_fire = 1'b1;
            end
            3'd1, 3'd2, 3'd3, 3'd4: begin
              state_d = BUSY;
              start_d = 1'b1;
`ifdef TINYALU_ARB_TIMEOUT_EN
              to_d    = '0;
`endif
            end
            default: begin
              state_d   = RESP;
              resp_fire = 1'b1;
              resp_err  = 1'b1;
            end
          endcase
        end
      end
      BUSY: begin
        start_d = 1'b1;
        // done has priority over the watchdog when both hit together
        if (bus.alu_done) begin
          state_d     = RESP;
          start_d     = 1'b0;
          resp_fire   = 1'b1;
          resp_result = bus.alu_result;
        end
`ifdef TINYALU_ARB_TIMEOUT_EN
        else if (to_q == TO_W'(TIMEOUT_CYCLES)) begin
          state_d   = RESP;
          start_d   = 1'b0;
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else begin
          to_d = to_q + TO_W'(1);
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        rr_d    = ~g_q;
      end
      default: state_d = IDLE;
    endcase

    // Response is loaded on the edge into RESP so it is visible throughout RESP.
    if (resp_fire) begin
      if (resp_g) begin
        rsp1_valid_d  = 1'b1;
        rsp1_result_d = resp_result;
        rsp1_err_d    = resp_err;
      end else begin
        rsp0_valid_d  = 1'b1;
        rsp0_result_d = resp_result;
        rsp0_err_d    = resp_err;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      rr_q          <= 1'b0;
      g_q           <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      op_q          <= '0;
      start_q       <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp1_result_q <= '0;
      rsp0_err_q    <= 1'b0;
      rsp1_err_q    <= 1'b0;
`ifdef TINYALU_ARB_TIMEOUT_EN
      to_q          <= '0;
`endif
    end else begin
      state_q       <= state_d;
      rr_q          <= rr_d;
      g_q           <= g_d;
      a_q           <= a_d;
      b_q           <= b_d;
      op_q          <= op_d;
      start_q       <= start_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp1_result_q <= rsp1_result_d;
      rsp0_err_q    <= rsp0_err_d;
      rsp1_err_q    <= rsp1_err_d;
`ifdef TINYALU_ARB_TIMEOUT_EN
      to_q          <= to_d;
`endif
    end
  end

  assign bus.req0_ready  = ready0_c;
  assign bus.req1_ready  = ready1_c;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_start   = start_q;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_result = rsp0_result_q;
  assign bus.rsp0_err    = rsp0_err_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_result = rsp1_result_q;
  assign bus.rsp1_err    = rsp1_err_q;

endmodule
